fetch_buf: RTL

FETCH_BUF -- requirements
Module: fetch_buf

---
 rtl/fetch_buf.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_buf.sv
// Instruction fetch buffer: a small circular FIFO between the fetch and decode stages.
// Define FETCH_BUF_BYPASS_EN to let an instruction pass straight through an empty buffer.
module fetch_buf #(
    parameter int XLEN      = 32,
    parameter int INSTR_LEN = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [INSTR_LEN-1:0]         in_instr,
    input  logic [XLEN-1:0]              in_tag,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [INSTR_LEN-1:0]         out_instr,
    output logic [XLEN-1:0]              out_tag,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INSTR_LEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0]      tag_mem   [DEPTH];

    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count_q;

    logic                 full;
    logic                 empty;
    logic                 push_en;
    logic                 pop_en;
    logic                 bypass_take;
    logic [INSTR_LEN-1:0] head_instr;
    logic [XLEN-1:0]      head_tag;
    logic [INSTR_LEN-1:0] last_instr;
    logic [XLEN-1:0]      last_tag;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = ~full;
    assign count    = count_q;

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass_hit;

    // An empty buffer forwards the incoming word; it is only stored if decode stalls.
    assign bypass_hit  = empty & in_valid & ~flush;
    assign bypass_take = bypass_hit & out_ready;
    assign out_valid   = ~flush & (~empty | in_valid);
    assign head_instr  = bypass_hit ? in_instr : instr_mem[rd_ptr];
    assign head_tag    = bypass_hit ? in_tag   : tag_mem[rd_ptr];
`else
    assign bypass_take = 1'b0;
    assign out_valid   = ~empty;
    assign head_instr  = instr_mem[rd_ptr];
    assign head_tag    = tag_mem[rd_ptr];
`endif

    assign push_en = in_valid & in_ready & ~flush & ~bypass_take;
    assign pop_en  = ~empty & out_ready & ~flush;

    // When nothing is valid, decode keeps seeing the last word it was shown.
    assign out_instr = out_valid ? head_instr : last_instr;
    assign out_tag   = out_valid ? head_tag   : last_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_instr <= '0;
            last_tag   <= '0;
        end else if (out_valid) begin
            last_instr <= head_instr;
            last_tag   <= head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            instr_mem[wr_ptr] <= in_instr;
            tag_mem[wr_ptr]   <= in_tag;
        end
    end

    // Pointer and occupancy state; a flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
